avr_tx_arbiter: RTL and testbench

- Shares the single FPGA-to-AVR serial transmit channel between NUM_REQ requesters.
- Transmission is gated by the cclk-derived link-ready signal and by the AVR's tx_block flow control.
- Round-robin arbitration with packet locking: the owner keeps the channel until it marks a byte as last.
- Sits between the requesting client blocks and the AVR interface transmit port.

---
 rtl/avr_tx_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_avr_tx_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/avr_tx_arbiter.sv
// avr_tx_arbiter
// Shares the single FPGA-to-AVR serial transmit channel between NUM_REQ
// requesters. A round-robin grant locks the channel to one requester until that
// requester sends a byte marked last. Transfers need the link-ready signal high
// and the AVR flow control (tx_block) low. Every output is registered.
//
// Optional feature macro: AVR_TX_ARB_TIMEOUT_EN
//   When defined, the lock is force-released (with an abort pulse) after
//   TIMEOUT consecutive LOCKED cycles without a transfer.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ready        link ready; low stops all activity and drops any lock
//   tx_block     AVR flow control; high stalls byte issue
//   req[i]       requester i has a byte pending (held until ack[i])
//   last[i]      requester i's current byte ends its packet
//   data[8i+7:8i] requester i's byte
//   ack[i]       one-cycle pulse: requester i's byte was taken
//   tx_data      byte to the AVR interface
//   new_tx_data  one-cycle strobe qualifying tx_data
//   owner        current lock owner index
//   owner_valid  high while a lock is held
//   abort        one-cycle pulse: lock lost before the last byte
module avr_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ready,
  input  logic                 tx_block,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   last,
  input  logic [8*NUM_REQ-1:0] data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [7:0]           tx_data,
  output logic                 new_tx_data,
  output logic [IDX_W-1:0]     owner,
  output logic                 owner_valid,
  output logic                 abort
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_IDLE   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Reject parameter sets the index and timeout logic cannot represent.
  if (NUM_REQ < 2 || NUM_REQ > 8 || IDX_W < $clog2(NUM_REQ) || TIMEOUT < 2) begin : g_bad_cfg
    $error("avr_tx_arbiter: illegal NUM_REQ/IDX_W/TIMEOUT combination");
  end

  state_t               state_r, state_next_s;
  logic [NUM_REQ-1:0]   ack_r, ack_next_s;
  logic [7:0]           tx_data_r, tx_data_next_s;
  logic                 new_r, new_next_s;
  logic [IDX_W-1:0]     owner_r, owner_next_s;
  logic                 owner_valid_r, owner_valid_next_s;
  logic                 abort_r, abort_next_s;
  logic [IDX_W-1:0]     rr_ptr_r, rr_ptr_next_s;

  logic                 own_req_s, own_last_s, own_ack_s;
  logic [7:0]           own_data_s;
  logic [NUM_REQ-1:0]   owner_oh_s;
  logic [IDX_W:0]       pick_s;
  logic                 xfer_s;
  logic                 timeout_s;

  // Round-robin pick: {found, index} of the first set bit after ptr, wrapping.
  // Scans farthest-to-nearest so the nearest hit is the one left in res.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDX_W-1:0]   ptr);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] k;
    res = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (r[k]) begin
        res = {1'b1, k};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Per-owner views of the requester buses, built with constant indices.
  always_comb begin
    own_req_s  = 1'b0;
    own_last_s = 1'b0;
    own_ack_s  = 1'b0;
    own_data_s = 8'h00;
    owner_oh_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == owner_r) begin
        own_req_s     = req[i];
        own_last_s    = last[i];
        own_ack_s     = ack_r[i];
        own_data_s    = data[8*i +: 8];
        owner_oh_s[i] = 1'b1;
      end else begin
        owner_oh_s[i] = 1'b0;
      end
    end
  end

  assign pick_s = rr_pick(req, rr_ptr_r);
  // The ack-high cycle blocks a transfer so a still-high req is not resent.
  assign xfer_s = (state_r == ST_LOCKED) && ready && own_req_s && !tx_block && !own_ack_s;

`ifdef AVR_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  logic [CNT_W-1:0] idle_cnt_r;

  // Idle counter for the lock: zero outside LOCKED (so zero on entry), cleared by transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_r <= '0;
    end else if (state_r != ST_LOCKED || xfer_s) begin
      idle_cnt_r <= '0;
    end else begin
      idle_cnt_r <= idle_cnt_r + CNT_W'(1);
    end
  end

  assign timeout_s = (state_r == ST_LOCKED) && !xfer_s && (idle_cnt_r == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and next-output logic; registered values hold unless changed.
  always_comb begin
    state_next_s       = state_r;
    ack_next_s         = '0;
    tx_data_next_s     = tx_data_r;
    new_next_s         = 1'b0;
    owner_next_s       = owner_r;
    owner_valid_next_s = owner_valid_r;
    abort_next_s       = 1'b0;
    rr_ptr_next_s      = rr_ptr_r;
    if (!ready) begin
      // Link loss wins over everything, including a transfer on this edge.
      state_next_s       = ST_OFF;
      owner_valid_next_s = 1'b0;
      if (state_r == ST_LOCKED) begin
        abort_next_s = 1'b1;
      end else begin
        abort_next_s = 1'b0;
      end
    end else begin
      case (state_r)
        ST_OFF: begin
          state_next_s = ST_IDLE;
        end
        ST_IDLE: begin
          if (pick_s[IDX_W]) begin
            owner_next_s       = pick_s[IDX_W-1:0];
            owner_valid_next_s = 1'b1;
            state_next_s       = ST_LOCKED;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (xfer_s) begin
            tx_data_next_s = own_data_s;
            new_next_s     = 1'b1;
            ack_next_s     = owner_oh_s;
            if (own_last_s) begin
              state_next_s       = ST_IDLE;
              rr_ptr_next_s      = owner_r;
              owner_valid_next_s = 1'b0;
            end else begin
              state_next_s = ST_LOCKED;
            end
          end else if (timeout_s) begin
            state_next_s       = ST_IDLE;
            rr_ptr_next_s      = owner_r;
            owner_valid_next_s = 1'b0;
            abort_next_s       = 1'b1;
          end else begin
            state_next_s = ST_LOCKED;
          end
        end
        default: begin
          state_next_s       = ST_OFF;
          owner_valid_next_s = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_OFF;
      ack_r         <= '0;
      tx_data_r     <= 8'h00;
      new_r         <= 1'b0;
      owner_r       <= '0;
      owner_valid_r <= 1'b0;
      abort_r       <= 1'b0;
      rr_ptr_r      <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_r       <= state_next_s;
      ack_r         <= ack_next_s;
      tx_data_r     <= tx_data_next_s;
      new_r         <= new_next_s;
      owner_r       <= owner_next_s;
      owner_valid_r <= owner_valid_next_s;
      abort_r       <= abort_next_s;
      rr_ptr_r      <= rr_ptr_next_s;
    end
  end

  assign ack         = ack_r;
  assign tx_data     = tx_data_r;
  assign new_tx_data = new_r;
  assign owner       = owner_r;
  assign owner_valid = owner_valid_r;
  assign abort       = abort_r;

endmodule

// File: tb/tb_avr_tx_arbiter.sv
// Testbench for avr_tx_arbiter (NUM_REQ=4, IDX_W=2). A vector table covers the
// single-byte and round-robin cases; hand-written sequences cover multi-byte
// packets, tx_block stalls, ready loss, asynchronous reset and, when
// AVR_TX_ARB_TIMEOUT_EN is defined, the lock timeout.
module tb_avr_tx_arbiter;

`ifdef AVR_TX_ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = 1024;
`endif

  logic        clk;
  logic        rst_n;
  logic        ready;
  logic        tx_block;
  logic [3:0]  req;
  logic [3:0]  last;
  logic [31:0] data;
  logic [3:0]  ack;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic [1:0]  owner;
  logic        owner_valid;
  logic        abort;

  int errors = 0;
  int checks = 0;

  avr_tx_arbiter #(.NUM_REQ(4), .IDX_W(2), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready), .tx_block(tx_block),
    .req(req), .last(last), .data(data), .ack(ack), .tx_data(tx_data),
    .new_tx_data(new_tx_data), .owner(owner), .owner_valid(owner_valid),
    .abort(abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time bound exceeded, got running expected finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rdy;
    logic        blk;
    logic [3:0]  rq;
    logic [3:0]  lst;
    logic [31:0] dat;
    logic [3:0]  e_ack;
    logic        e_new;
    logic [7:0]  e_tx;
    logic        e_ov;
    logic [1:0]  e_own;
    logic        e_ab;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic rdy, input logic blk, input logic [3:0] rq,
                              input logic [3:0] lst, input logic [31:0] dat,
                              input logic [3:0] e_ack, input logic e_new, input logic [7:0] e_tx,
                              input logic e_ov, input logic [1:0] e_own, input logic e_ab);
    vec_t v;
    v.rdy = rdy; v.blk = blk; v.rq = rq; v.lst = lst; v.dat = dat;
    v.e_ack = e_ack; v.e_new = e_new; v.e_tx = e_tx; v.e_ov = e_ov; v.e_own = e_own; v.e_ab = e_ab;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic expect_out(input string nm, input logic [3:0] e_ack, input logic e_new,
                            input logic [7:0] e_tx, input logic e_ov, input logic [1:0] e_own,
                            input logic e_ab);
    chk({nm, ".ack"},         {28'd0, ack},         {28'd0, e_ack});
    chk({nm, ".new_tx_data"}, {31'd0, new_tx_data}, {31'd0, e_new});
    chk({nm, ".tx_data"},     {24'd0, tx_data},     {24'd0, e_tx});
    chk({nm, ".owner_valid"}, {31'd0, owner_valid}, {31'd0, e_ov});
    chk({nm, ".owner"},       {30'd0, owner},       {30'd0, e_own});
    chk({nm, ".abort"},       {31'd0, abort},       {31'd0, e_ab});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic blk, input logic [3:0] rq,
                       input logic [3:0] lst, input logic [31:0] dat);
    ready = rdy; tx_block = blk; req = rq; last = lst; data = dat;
  endtask

  localparam logic [31:0] DW = 32'h3300_11A5;  // slot0=A5 slot1=11 slot3=33

  initial begin
    // Single-byte from 0, then two round-robin rounds over requesters 1 and 3.
    vecs[0]  = mk(1'b1, 1'b0, 4'b0000, 4'b0000, DW, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 4'b0001, 4'b0001, DW, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0);
    vecs[2]  = mk(1'b1, 1'b0, 4'b0001, 4'b0001, DW, 4'b0001, 1'b1, 8'hA5, 1'b0, 2'd0, 1'b0);
    vecs[3]  = mk(1'b1, 1'b0, 4'b0000, 4'b0000, DW, 4'b0000, 1'b0, 8'hA5, 1'b0, 2'd0, 1'b0);
    vecs[4]  = mk(1'b1, 1'b0, 4'b1010, 4'b1010, DW, 4'b0000, 1'b0, 8'hA5, 1'b1, 2'd1, 1'b0);
    vecs[5]  = mk(1'b1, 1'b0, 4'b1010, 4'b1010, DW, 4'b0010, 1'b1, 8'h11, 1'b0, 2'd1, 1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 4'b1000, 4'b1010, DW, 4'b0000, 1'b0, 8'h11, 1'b1, 2'd3, 1'b0);
    vecs[7]  = mk(1'b1, 1'b0, 4'b1000, 4'b1010, DW, 4'b1000, 1'b1, 8'h33, 1'b0, 2'd3, 1'b0);
    vecs[8]  = mk(1'b1, 1'b0, 4'b0000, 4'b1010, DW, 4'b0000, 1'b0, 8'h33, 1'b0, 2'd3, 1'b0);
    vecs[9]  = mk(1'b1, 1'b0, 4'b1010, 4'b1010, DW, 4'b0000, 1'b0, 8'h33, 1'b1, 2'd1, 1'b0);
    vecs[10] = mk(1'b1, 1'b0, 4'b1010, 4'b1010, DW, 4'b0010, 1'b1, 8'h11, 1'b0, 2'd1, 1'b0);
    vecs[11] = mk(1'b1, 1'b0, 4'b1000, 4'b1010, DW, 4'b0000, 1'b0, 8'h11, 1'b1, 2'd3, 1'b0);
    vecs[12] = mk(1'b1, 1'b0, 4'b1000, 4'b1010, DW, 4'b1000, 1'b1, 8'h33, 1'b0, 2'd3, 1'b0);
    vecs[13] = mk(1'b1, 1'b0, 4'b0000, 4'b0000, DW, 4'b0000, 1'b0, 8'h33, 1'b0, 2'd3, 1'b0);

    // Reset values.
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0);
    step();
    step();
    expect_out("reset", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;

    // Link not ready: a pending request must never be served.
    drive(1'b0, 1'b0, 4'b0001, 4'b0001, DW);
    for (int c = 0; c < 20; c++) begin
      step();
      chk($sformatf("notready%0d.new_tx_data", c), {31'd0, new_tx_data}, 32'd0);
      chk($sformatf("notready%0d.ack", c),         {28'd0, ack},         32'd0);
      chk($sformatf("notready%0d.owner_valid", c), {31'd0, owner_valid}, 32'd0);
    end

    for (int v = 0; v < 14; v++) begin
      drive(vecs[v].rdy, vecs[v].blk, vecs[v].rq, vecs[v].lst, vecs[v].dat);
      step();
      expect_out($sformatf("vec%0d", v), vecs[v].e_ack, vecs[v].e_new, vecs[v].e_tx,
                 vecs[v].e_ov, vecs[v].e_own, vecs[v].e_ab);
    end

    // Packet lock: requester 2 sends 10,11,12 while requester 0 waits.
    drive(1'b1, 1'b0, 4'b0100, 4'b0000, 32'h0010_0000);
    step(); expect_out("lockA_grant", 4'b0000, 1'b0, 8'h33, 1'b1, 2'd2, 1'b0);
    drive(1'b1, 1'b0, 4'b0101, 4'b0001, 32'h0010_00A5);
    step(); expect_out("lockA_b0", 4'b0100, 1'b1, 8'h10, 1'b1, 2'd2, 1'b0);
    data = 32'h0011_00A5;
    step(); expect_out("lockA_gap0", 4'b0000, 1'b0, 8'h10, 1'b1, 2'd2, 1'b0);
    step(); expect_out("lockA_b1", 4'b0100, 1'b1, 8'h11, 1'b1, 2'd2, 1'b0);
    data = 32'h0012_00A5; last = 4'b0101;
    step(); expect_out("lockA_gap1", 4'b0000, 1'b0, 8'h11, 1'b1, 2'd2, 1'b0);
    step(); expect_out("lockA_b2", 4'b0100, 1'b1, 8'h12, 1'b0, 2'd2, 1'b0);
    req = 4'b0001;
    step(); expect_out("lockA_grant0", 4'b0000, 1'b0, 8'h12, 1'b1, 2'd0, 1'b0);
    step(); expect_out("lockA_req0", 4'b0001, 1'b1, 8'hA5, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 4'b0000, 4'b0000, 32'h0);
    step(); expect_out("lockA_quiet", 4'b0000, 1'b0, 8'hA5, 1'b0, 2'd0, 1'b0);

    // tx_block held 10 cycles between the two bytes of requester 1.
    drive(1'b1, 1'b0, 4'b0010, 4'b0000, 32'h0000_2100);
    step(); expect_out("blk_grant", 4'b0000, 1'b0, 8'hA5, 1'b1, 2'd1, 1'b0);
    step(); expect_out("blk_b0", 4'b0010, 1'b1, 8'h21, 1'b1, 2'd1, 1'b0);
    drive(1'b1, 1'b1, 4'b0010, 4'b0010, 32'h0000_2200);
    for (int c = 0; c < 10; c++) begin
      step(); expect_out($sformatf("blk_hold%0d", c), 4'b0000, 1'b0, 8'h21, 1'b1, 2'd1, 1'b0);
    end
    tx_block = 1'b0;
    step(); expect_out("blk_b1", 4'b0010, 1'b1, 8'h22, 1'b0, 2'd1, 1'b0);
    drive(1'b1, 1'b0, 4'b0000, 4'b0000, 32'h0);
    step(); expect_out("blk_quiet", 4'b0000, 1'b0, 8'h22, 1'b0, 2'd1, 1'b0);

    // ready falls after the first of three bytes from requester 3.
    drive(1'b1, 1'b0, 4'b1000, 4'b0000, 32'h3100_0000);
    step(); expect_out("rdy_grant", 4'b0000, 1'b0, 8'h22, 1'b1, 2'd3, 1'b0);
    step(); expect_out("rdy_b0", 4'b1000, 1'b1, 8'h31, 1'b1, 2'd3, 1'b0);
    drive(1'b0, 1'b0, 4'b1000, 4'b0000, 32'h3200_0000);
    step(); expect_out("rdy_abort", 4'b0000, 1'b0, 8'h31, 1'b0, 2'd3, 1'b1);
    for (int c = 0; c < 4; c++) begin
      step(); expect_out($sformatf("rdy_off%0d", c), 4'b0000, 1'b0, 8'h31, 1'b0, 2'd3, 1'b0);
    end
    drive(1'b1, 1'b0, 4'b0000, 4'b0000, 32'h0);
    step(); expect_out("rdy_back", 4'b0000, 1'b0, 8'h31, 1'b0, 2'd3, 1'b0);

    // Asynchronous reset in mid-packet: immediate clear, no abort.
    drive(1'b1, 1'b0, 4'b0001, 4'b0000, 32'h0000_00D1);
    step(); expect_out("arst_grant", 4'b0000, 1'b0, 8'h31, 1'b1, 2'd0, 1'b0);
    step(); expect_out("arst_b0", 4'b0001, 1'b1, 8'hD1, 1'b1, 2'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1 expect_out("arst_now", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    step(); expect_out("arst_held", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 4'b0000, 4'b0000, 32'h0);
    rst_n = 1'b1;
    step(); expect_out("arst_rel", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);

`ifdef AVR_TX_ARB_TIMEOUT_EN
    // Owner goes silent mid-packet; lock released after TIMEOUT idle cycles.
    drive(1'b1, 1'b0, 4'b0001, 4'b0000, 32'h0000_0041);
    step(); expect_out("to_grant", 4'b0000, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0);
    step(); expect_out("to_b0", 4'b0001, 1'b1, 8'h41, 1'b1, 2'd0, 1'b0);
    req = 4'b0100;
    for (int c = 1; c < TB_TIMEOUT; c++) begin
      step(); expect_out($sformatf("to_wait%0d", c), 4'b0000, 1'b0, 8'h41, 1'b1, 2'd0, 1'b0);
    end
    step(); expect_out("to_abort", 4'b0000, 1'b0, 8'h41, 1'b0, 2'd0, 1'b1);
    step(); expect_out("to_regrant", 4'b0000, 1'b0, 8'h41, 1'b1, 2'd2, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
